// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Datapath width of the attached combinational ALU.
    localparam int ALU_W = 8;

    // Command opcodes as presented on cmd_op.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_CMP = 2'b11
    } op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MULT = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_op_sequencer_flag_calc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_calc
//  Description : Carry and zero flag derivation for one ALU operation. The
//                carry is the carry-out of a (WIDTH+1)-bit recomputation of
//                a + (b ^ sub) + sub, which for subtraction is the no-borrow
//                flag (a >= b unsigned). Zero is taken from the real ALU sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_calc
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zero
);

    // Operand B as the ALU sees it (inverted when subtracting).
    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = b ^ {WIDTH{sub}};

    // Only the top bit of the widened sum is needed, so it is extracted
    // in-expression rather than kept as a mostly-unused wide signal.
    assign carry = 1'(({1'b0, a} + {1'b0, w_b_eff} + (WIDTH+1)'(sub)) >> WIDTH);

    assign zero  = (sum == '0);

endmodule : alu_flag_calc
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Initiator for the 8-bit combinational ALU. Accepts commands
//                over valid/ready, drives the ALU operand/subtract lines,
//                derives carry/zero flags and returns the result over a
//                valid/ready response channel. Multiply is performed as b
//                repeated additions of a through the same ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = ALU_W,   // only 8 is supported by the ALU
    parameter bit MUL_EN = 1'b1     // 0: OP_MUL executes as OP_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_cnt;       // remaining additions in MULT
    logic             r_sticky;    // any intermediate multiply overflow

    op_e              w_cmd_op;
    logic             w_carry;
    logic             w_zero;

    assign w_cmd_op = op_e'(cmd_op);
    assign busy     = (r_state != IDLE);

    // Flags for whatever the ALU is currently computing (EXEC or MULT step).
    alu_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .a     (alu_a),
        .b     (alu_b),
        .sub   (alu_sub),
        .sum   (alu_out),
        .carry (w_carry),
        .zero  (w_zero)
    );

    // Control FSM with registered handshake, ALU-drive and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_ADD;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            cmd_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sub   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // cmd_ready is high throughout IDLE, so valid alone accepts.
                    if (cmd_valid) begin
                        r_op      <= w_cmd_op;
                        cmd_ready <= 1'b0;
                        if (MUL_EN && (w_cmd_op == OP_MUL)) begin
                            if (cmd_b == '0) begin
                                // Product is trivially zero; ALU lines untouched.
                                r_state   <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                                rsp_carry <= 1'b0;
                                rsp_zero  <= 1'b1;
                            end else begin
                                // alu_a doubles as the accumulator, starting at 0.
                                r_state  <= MULT;
                                alu_a    <= '0;
                                alu_b    <= cmd_a;
                                alu_sub  <= 1'b0;
                                r_cnt    <= cmd_b;
                                r_sticky <= 1'b0;
                            end
                        end else begin
                            r_state <= EXEC;
                            alu_a   <= cmd_a;
                            alu_b   <= cmd_b;
                            alu_sub <= (w_cmd_op == OP_SUB) || (w_cmd_op == OP_CMP);
                        end
                    end
                end

                EXEC: begin
                    r_state   <= DONE;
                    rsp_valid <= 1'b1;
                    // CMP keeps only the flags; A is passed through as data.
                    rsp_data  <= (r_op == OP_CMP) ? alu_a : alu_out;
                    rsp_carry <= w_carry;
                    rsp_zero  <= w_zero;
                end

                MULT: begin
                    alu_a    <= alu_out;
                    r_cnt    <= r_cnt - WIDTH'(1);
                    r_sticky <= r_sticky | w_carry;
                    if (r_cnt == WIDTH'(1)) begin
                        r_state   <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= alu_out;
                        rsp_carry <= r_sticky | w_carry;
                        rsp_zero  <= w_zero;
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : alu_op_sequencer
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                behavioural ALU model and an expected-response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_valid_n = 1'b0;
    logic       rsp_ready = 1'b0, rsp_ready_n = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;

    logic       cmd_ready, alu_sub, rsp_valid, rsp_carry, rsp_zero, busy;
    logic [7:0] alu_a, alu_b, alu_out, rsp_data;
    logic       cmd_ready_n, alu_sub_n, rsp_valid_n, rsp_carry_n, rsp_zero_n, busy_n;
    logic [7:0] alu_a_n, alu_b_n, alu_out_n, rsp_data_n;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // Combinational ALUs: a + (b ^ {8{sub}}) + sub
    assign alu_out   = alu_a   + (alu_b   ^ {8{alu_sub}})   + {7'b0, alu_sub};
    assign alu_out_n = alu_a_n + (alu_b_n ^ {8{alu_sub_n}}) + {7'b0, alu_sub_n};

    alu_op_sequencer #(.WIDTH(8), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
    );

    alu_op_sequencer #(.WIDTH(8), .MUL_EN(1'b0)) u_dut_nomul (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_n), .cmd_ready(cmd_ready_n),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a_n), .alu_b(alu_b_n), .alu_sub(alu_sub_n), .alu_out(alu_out_n),
        .rsp_valid(rsp_valid_n), .rsp_ready(rsp_ready_n), .rsp_data(rsp_data_n),
        .rsp_carry(rsp_carry_n), .rsp_zero(rsp_zero_n), .busy(busy_n)
    );

    // Reference arithmetic written directly from the operation definitions.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic mul_en);
        exp_t        e;
        logic [8:0]  s9;
        logic [15:0] p;
        logic [1:0]  eff_op;
        eff_op = (op == 2'b10 && !mul_en) ? 2'b00 : op;
        case (eff_op)
            2'b00: begin s9 = {1'b0, a} + {1'b0, b}; e.data = s9[7:0]; e.carry = s9[8]; end
            2'b01: begin e.data = a - b; e.carry = (a >= b); end
            2'b11: begin e.data = a;     e.carry = (a >= b); end
            default: begin p = a * b; e.data = p[7:0]; e.carry = (p > 16'd255); end
        endcase
        e.zero = (eff_op == 2'b11) ? (a == b) : (e.data == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command to the main DUT; returns one step after the accept edge.
    task automatic issue(input string tag, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        sb.push_back(model(op, a, b, 1'b1));
        tick();
        cmd_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge (inclusive) to rsp_valid.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 1;
        while (!rsp_valid && lat < 400) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Compare the presented response with the scoreboard head and take it.
    task automatic drain(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"},  32'(rsp_data),  32'(e.data));
            check({tag, "_carry"}, 32'(rsp_carry), 32'(e.carry));
            check({tag, "_zero"},  32'(rsp_zero),  32'(e.zero));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_low"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"},          32'(busy),      32'd0);
        check({tag, "_ready_again"},   32'(cmd_ready), 32'd1);
    endtask

    initial begin : stimulus
        exp_t en;

        // Power-on reset
        tick(); tick();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);

        // Reset in the middle of a long multiply abandons it
        issue("mulrst", 2'b10, 8'd3, 8'd200);
        repeat (10) tick();
        check("mulrst_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("mulrst_busy",      32'(busy),      32'd0);
        check("mulrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mulrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mulrst_outs", {8'h00, rsp_data, alu_a, alu_b},         32'h0);
        check("mulrst_flags", {29'h0, rsp_carry, rsp_zero, alu_sub},  32'h0);
        repeat (3) tick();
        check("mulrst_no_rsp", 32'(rsp_valid), 32'd0);

        // ADD with carry-out
        issue("add_f0_20", 2'b00, 8'hF0, 8'h20);
        check("add_f0_20_sub",  32'(alu_sub),   32'd0);
        check("add_f0_20_busy", 32'(busy),      32'd1);
        check("add_f0_20_nrdy", 32'(cmd_ready), 32'd0);
        wait_valid("add_f0_20", 2);
        check("add_f0_20_hold_a", 32'(alu_a), 32'hF0);
        check("add_f0_20_hold_b", 32'(alu_b), 32'h20);
        drain("add_f0_20");

        // ADD wrapping exactly to zero
        issue("add_ff_01", 2'b00, 8'hFF, 8'h01);
        wait_valid("add_ff_01", 2);
        drain("add_ff_01");

        // SUB equal and SUB with borrow
        issue("sub_05_05", 2'b01, 8'h05, 8'h05);
        check("sub_05_05_sub", 32'(alu_sub), 32'd1);
        wait_valid("sub_05_05", 2);
        drain("sub_05_05");
        issue("sub_03_05", 2'b01, 8'h03, 8'h05);
        wait_valid("sub_03_05", 2);
        drain("sub_03_05");

        // Multiplies: small, overflowing, and zero multiplier
        issue("mul_07_06", 2'b10, 8'h07, 8'h06);
        check("mul_07_06_sub", 32'(alu_sub), 32'd0);
        wait_valid("mul_07_06", 7);
        drain("mul_07_06");
        issue("mul_10_11", 2'b10, 8'h10, 8'h11);
        wait_valid("mul_10_11", 18);
        drain("mul_10_11");
        issue("mul_55_00", 2'b10, 8'h55, 8'h00);
        wait_valid("mul_55_00", 1);
        drain("mul_55_00");

        // Backpressure: response holds and new commands are refused
        issue("bp_add", 2'b00, 8'h01, 8'h02);
        wait_valid("bp_add", 2);
        for (int i = 0; i < 5; i++) begin
            cmd_op = 2'b01; cmd_a = 8'h99; cmd_b = 8'h11; cmd_valid = 1'b1;
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_data_hold",  32'(rsp_data),  32'h03);
            check("bp_cmd_refused", 32'(cmd_ready), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_valid_end", 32'(rsp_valid), 32'd1);
        drain("bp_add");

        // CMP: A passes through, flags as for SUB
        issue("cmp_40_41", 2'b11, 8'h40, 8'h41);
        check("cmp_40_41_sub", 32'(alu_sub), 32'd1);
        wait_valid("cmp_40_41", 2);
        drain("cmp_40_41");

        // Build without multiply: op 10 behaves as ADD with a one-cycle EXEC
        en = model(2'b10, 8'd3, 8'd4, 1'b0);
        check("nomul_cmd_ready", 32'(cmd_ready_n), 32'd1);
        cmd_op = 2'b10; cmd_a = 8'd3; cmd_b = 8'd4; cmd_valid_n = 1'b1;
        tick();
        cmd_valid_n = 1'b0;
        check("nomul_busy", 32'(busy_n),    32'd1);
        check("nomul_sub",  32'(alu_sub_n), 32'd0);
        tick();
        check("nomul_valid", 32'(rsp_valid_n), 32'd1);
        check("nomul_data",  32'(rsp_data_n),  32'(en.data));
        check("nomul_carry", 32'(rsp_carry_n), 32'(en.carry));
        check("nomul_zero",  32'(rsp_zero_n),  32'(en.zero));
        rsp_ready_n = 1'b1;
        tick();
        rsp_ready_n = 1'b0;
        check("nomul_idle", 32'(rsp_valid_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_op_sequencer
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU datapath interface.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand and subtract lines.
- Captures the ALU sum, derives carry and zero flags, and returns the result over a valid/ready response channel.
- Adds a multi-cycle multiply built from repeated ALU additions; sits between the control sequencer/bus and the combinational ALU.

Parameters:
- WIDTH, 8, datapath width; must match the ALU (only 8 is supported).
- MUL_EN, 1, 1 enables OP_MUL; 0 makes OP_MUL execute as OP_ADD.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 CMP
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_sub  output  1  to ALU sub
- alu_out  input  WIDTH  from ALU out (combinational: a + (b^{W{sub}}) + sub)
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes result
- rsp_data  output  WIDTH  result
- rsp_carry  output  1  carry flag
- rsp_zero  output  1  zero flag
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, alu_a=0, alu_b=0, alu_sub=0, busy=0.
- Reset mid-operation abandons the operation: no response is produced and the state returns to IDLE.
- FSM states: IDLE, EXEC, MULT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/a/b.
  - Go to EXEC for ADD/SUB/CMP, and for MUL with MUL_EN=0.
  - Go to MULT for MUL with MUL_EN=1 and b!=0.
  - Go directly to DONE with data=0, carry=0, zero=1 for MUL with b==0.
- cmd_ready=0 in every state other than IDLE. Commands are never accepted back-to-back with an outstanding response.
- EXEC (exactly 1 cycle):
  - alu_a=a_q, alu_b=b_q, alu_sub=1 for SUB/CMP, else 0.
  - At the end of the cycle, latch flags and data, then go to DONE.
  - ADD: data=alu_out; carry = 9-bit carry-out of a_q+b_q.
  - SUB: data=alu_out; carry = no-borrow = (a_q >= b_q unsigned).
  - CMP: carry and zero as SUB; data=a_q (result discarded, A passed through).
  - zero = (alu_out == 0) for all three.
- Latency: rsp_valid rises on the clock edge after the EXEC cycle, i.e. 2 cycles after the accept edge for ADD/SUB/CMP.
- MULT:
  - Entry: acc=0, cnt=b_q, sticky carry cleared.
  - Each cycle: alu_a=acc, alu_b=a_q, alu_sub=0; acc<=alu_out; cnt<=cnt-1.
  - Sticky carry |= carry-out of acc+a_q.
  - When cnt==1 at a clock edge, that edge is the final add; go to DONE with data=final acc, carry=sticky, zero=(final acc==0).
  - MUL latency: b_q cycles in MULT plus 1; result is the low 8 bits of a*b.
- DONE:
  - rsp_valid=1; rsp_data/flags stable while rsp_valid&&!rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid=0 on the next cycle.
  - rsp_ready while not in DONE is ignored.
- ALU outputs in IDLE/DONE hold their last driven values (no glitching to 0).
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Carry is computed internally from 9-bit sums; the 8-bit alu_out is never widened.

Decomposition:
- Package alu_seq_pkg: op_e enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_CMP=2'b11), state_e enum (IDLE, EXEC, MULT, DONE), localparam ALU_W=8.
- Sub-module alu_flag_calc (combinational): inputs a, b, sub, sum; outputs carry (add carry-out or no-borrow) and zero. Used by both EXEC and MULT.

Test Plan:
- Reset during MULT with a=3, b=200 -> next cycle: state IDLE, cmd_ready=1, rsp_valid=0, all outputs 0.
- ADD a=0xF0, b=0x20 -> alu_sub=0 in EXEC; rsp_valid 2 cycles after accept; data=0x10, carry=1, zero=0.
- SUB a=0x05, b=0x05 -> alu_sub=1; data=0x00, carry=1, zero=1. Then SUB a=0x03, b=0x05 -> data=0xFE, carry=0, zero=0.
- MUL a=0x07, b=0x06 -> 6 cycles in MULT; data=0x2A, carry=0. MUL a=0x10, b=0x11 -> data=0x10, carry=1. MUL a=0x55, b=0 -> DONE directly, data=0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after ADD 0x01+0x02 -> rsp_valid=1, data=0x03 stable; cmd_valid with new op ignored (cmd_ready=0); on rsp_ready, IDLE next cycle.
- CMP a=0x40, b=0x41 -> data=0x40, carry=0, zero=0. MUL_EN=0 build: op 10 a=3, b=4 -> data=0x07 with 1-cycle EXEC.
